bus_slave_sel: RTL and testbench
================================

BUS_SLAVE_SEL -- requirements
Module: bus_slave_sel

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, meaning bus word-address width.
REQ-002 SHALL have parameter IDX_W, default 3, meaning number of top address bits used as the slave index.
REQ-003 SHALL have parameter N_SLAVES, default 8, meaning number of attached slaves; legal range 1..2**IDX_W.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for slave ready; legal range 1..65535.
REQ-005 clk  input  1  bus clock; all state changes on its rising edge.
REQ-006 reset_  input  1  reset, asynchronous, active-low.
REQ-007 m_as_  input  1  master address strobe, active-low; requests a transaction.
REQ-008 m_addr  input  ADDR_W  master address; sampled only when m_as_ is accepted.
REQ-009 s_rdy_  input  N_SLAVES  per-slave ready, active-low; bit i belongs to slave i.
REQ-010 s_cs_  output  N_SLAVES  per-slave chip select, active-low, registered.
REQ-011 m_rdy_  output  1  transaction complete to master, active-low, one-cycle pulse.
REQ-012 m_err  output  1  error flag, active-high, valid only in the cycle m_rdy_ is low.
REQ-013 busy  output  1  high while a transaction is outstanding.

Function
REQ-014 Slave index SHALL be m_addr[ADDR_W-1 : ADDR_W-IDX_W], treated as unsigned.
REQ-015 FSM states SHALL be IDLE, WAIT, DONE, ERR.
REQ-016 IDLE: m_as_ low with index < N_SLAVES -> WAIT next edge; index latched; s_cs_[index] driven low from that edge.
REQ-017 IDLE: m_as_ low with index >= N_SLAVES -> ERR next edge; no s_cs_ bit asserted.
REQ-018 IDLE: m_as_ high -> stay IDLE; all s_cs_ high.
REQ-019 WAIT: only s_rdy_[latched index] SHALL be observed; other s_rdy_ bits ignored.
REQ-020 WAIT: observed s_rdy_ low -> DONE next edge; s_cs_ deasserted (all high) at that same edge.
REQ-021 WAIT: timeout counter SHALL clear on entering WAIT and increment each WAIT cycle; after TIMEOUT WAIT cycles without ready -> ERR next edge, s_cs_ all high.
REQ-022 Simultaneous ready and timeout in the same cycle: ready SHALL win (DONE, m_err low).
REQ-023 DONE: m_rdy_ low, m_err low for exactly one cycle, then IDLE.
REQ-024 ERR: m_rdy_ low, m_err high for exactly one cycle, then IDLE.
REQ-025 m_as_ SHALL be ignored in WAIT, DONE and ERR; a new request is accepted earliest in the IDLE cycle following DONE/ERR.
REQ-026 Latency: ready slave (s_rdy_ low in first WAIT cycle) -> m_rdy_ low 2 cycles after m_as_ accepted.
REQ-027 At most one s_cs_ bit SHALL be low at any time.
REQ-028 busy SHALL be high in WAIT, DONE, ERR; low in IDLE.
REQ-029 Counter width SHALL be 16 bits; no wrap-around reachable because TIMEOUT <= 65535.

Reset
REQ-030 reset_ low SHALL asynchronously force IDLE, s_cs_ all ones, m_rdy_ high, m_err low, busy low, counter and latched index zero.
REQ-031 reset_ asserted mid-transaction SHALL abort it with no m_rdy_ pulse; selected s_cs_ deasserts immediately.
REQ-032 After reset_ release, first request SHALL be accepted on the first rising edge with m_as_ low.

Verification
REQ-033 Defaults, m_addr=30'h0800_0000 (index 1), s_rdy_[1] low immediately -> s_cs_=8'hFD for 1 cycle, m_rdy_ low 2 cycles after strobe, m_err=0.
REQ-034 N_SLAVES=5, index 6 -> no s_cs_ bit low, m_rdy_ low with m_err=1 one cycle after strobe.
REQ-035 TIMEOUT=4, index 3, s_rdy_ held high -> s_cs_[3] low for exactly 4 cycles, then m_rdy_ low with m_err=1.
REQ-036 TIMEOUT=4, s_rdy_[3] goes low in 4th WAIT cycle -> DONE, m_err=0; s_rdy_[2] low during WAIT ignored.
REQ-037 reset_ pulsed low during WAIT -> s_cs_ all ones same cycle, no m_rdy_ pulse, busy low.
REQ-038 m_as_ held low continuously, slave always ready -> back-to-back transactions each 3 cycles long, never two s_cs_ bits low together.

Source files
------------

// File: rtl/bus_slave_sel_if.sv
// Bus bundle between a master, the slave selector and its attached slaves.
// All strobes and ready/select lines are active-low (trailing underscore).
interface bus_slave_sel_if #(
  parameter int ADDR_W   = 30,
  parameter int N_SLAVES = 8
);
  logic                m_as_;
  logic [ADDR_W-1:0]   m_addr;
  logic [N_SLAVES-1:0] s_rdy_;
  logic [N_SLAVES-1:0] s_cs_;
  logic                m_rdy_;
  logic                m_err;
  logic                busy;

  // Selector side: takes the master request and slave readies, drives selects and completion.
  modport slave (
    input  m_as_, m_addr, s_rdy_,
    output s_cs_, m_rdy_, m_err, busy
  );

  // Environment side: master request plus slave ready lines, observes the selector outputs.
  modport master (
    output m_as_, m_addr, s_rdy_,
    input  s_cs_, m_rdy_, m_err, busy
  );
endinterface

// File: rtl/bus_slave_sel.sv
// Address-decoding slave selector. The top IDX_W address bits pick one of
// N_SLAVES chip selects; the selected slave's ready (or a timeout, or an
// out-of-range index) ends the transaction with a one-cycle m_rdy_ pulse.
module bus_slave_sel #(
  parameter int ADDR_W   = 30,
  parameter int IDX_W    = 3,
  parameter int N_SLAVES = 8,
  parameter int TIMEOUT  = 255
) (
  input logic           clk,
  input logic           reset_,
  bus_slave_sel_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Last counter value still allowed to wait; ERR follows when it is reached without ready.
  localparam logic [15:0]    TMO_LAST = 16'(TIMEOUT - 1);
  // One extra bit so N_SLAVES == 2**IDX_W is representable.
  localparam logic [IDX_W:0] N_LIM    = (IDX_W + 1)'(N_SLAVES);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [N_SLAVES-1:0] cs_q, cs_d;
  logic                m_rdy_q, m_rdy_d;
  logic                m_err_q, m_err_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    req_idx_s;
  logic                req_valid_s;
  logic [N_SLAVES-1:0] req_sel_s;
  logic [N_SLAVES-1:0] wait_sel_s;
  logic                sel_rdy_s;
  logic                tmo_s;
  logic                unused_addr_s;

  assign req_idx_s     = bus.m_addr[ADDR_W-1 -: IDX_W];
  assign req_valid_s   = ({1'b0, req_idx_s} < N_LIM);
  assign unused_addr_s = ^bus.m_addr[ADDR_W-IDX_W-1:0];

  // One-hot decode of the requested index and of the latched index.
  always_comb begin
    req_sel_s  = '0;
    wait_sel_s = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      req_sel_s[i]  = (req_idx_s == IDX_W'(i));
      wait_sel_s[i] = (idx_q == IDX_W'(i));
    end
  end

  // Only the latched slave's ready is looked at; the rest are masked off.
  assign sel_rdy_s = |(wait_sel_s & ~bus.s_rdy_);
  assign tmo_s     = (cnt_q == TMO_LAST);

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cs_d    = '1;
    m_rdy_d = 1'b1;
    m_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.m_as_) begin
          if (req_valid_s) begin
            state_d = WAIT;
            idx_d   = req_idx_s;
            cnt_d   = 16'd0;
            cs_d    = ~req_sel_s;
          end else begin
            state_d = ERR;
            m_rdy_d = 1'b0;
            m_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Ready is tested first so it wins over a coincident timeout.
        if (sel_rdy_s) begin
          state_d = DONE;
          m_rdy_d = 1'b0;
        end else if (tmo_s) begin
          state_d = ERR;
          m_rdy_d = 1'b0;
          m_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
          cs_d  = ~wait_sel_s;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any selected slave immediately.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= 16'd0;
      cs_q    <= '1;
      m_rdy_q <= 1'b1;
      m_err_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      m_rdy_q <= m_rdy_d;
      m_err_q <= m_err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.s_cs_  = cs_q;
  assign bus.m_rdy_ = m_rdy_q;
  assign bus.m_err  = m_err_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_bus_slave_sel.sv
// Bench for bus_slave_sel: one instance with 8 slaves and a short timeout,
// one with 5 slaves for out-of-range indices. Expected outputs come from
// a vector table and go through a scoreboard queue.
module tb_bus_slave_sel;

  logic clk = 1'b0;
  logic reset_;

  always #5 clk = ~clk;

  bus_slave_sel_if #(.ADDR_W(30), .N_SLAVES(8)) bus_a ();
  bus_slave_sel_if #(.ADDR_W(30), .N_SLAVES(5)) bus_b ();

  bus_slave_sel #(.ADDR_W(30), .IDX_W(3), .N_SLAVES(8), .TIMEOUT(4)) dut_a (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_a)
  );

  bus_slave_sel #(.ADDR_W(30), .IDX_W(3), .N_SLAVES(5), .TIMEOUT(255)) dut_b (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_b)
  );

  typedef struct packed {
    logic       which;   // 0: dut_a, 1: dut_b
    logic       as_;
    logic [2:0] idx;
    logic [7:0] rdy;
    logic [7:0] cs;      // dut_b compares against {3'b111, s_cs_}
    logic       mrdy;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  function automatic vec_t mk(input logic w, input logic a, input logic [2:0] i,
                              input logic [7:0] r, input logic [7:0] c,
                              input logic mr, input logic e, input logic b);
    vec_t v;
    v.which = w; v.as_ = a; v.idx = i; v.rdy = r;
    v.cs = c; v.mrdy = mr; v.err = e; v.busy = b;
    return v;
  endfunction

  function automatic logic [10:0] obs(input logic which);
    if (which == 1'b0)
      return {bus_a.s_cs_, bus_a.m_rdy_, bus_a.m_err, bus_a.busy};
    else
      return {3'b111, bus_b.s_cs_, bus_b.m_rdy_, bus_b.m_err, bus_b.busy};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got cs=%h rdy_=%b err=%b busy=%b, want cs=%h rdy_=%b err=%b busy=%b",
               name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic which, input logic as_, input logic [2:0] idx,
                       input logic [7:0] rdy);
    logic [26:0] low;
    low = 27'($urandom);
    if (which == 1'b0) begin
      bus_a.m_as_  = as_;
      bus_a.m_addr = {idx, low};
      bus_a.s_rdy_ = rdy;
      bus_b.m_as_  = 1'b1;
      bus_b.m_addr = 30'h0;
      bus_b.s_rdy_ = 5'h1F;
    end else begin
      bus_b.m_as_  = as_;
      bus_b.m_addr = {idx, low};
      bus_b.s_rdy_ = rdy[4:0];
      bus_a.m_as_  = 1'b1;
      bus_a.m_addr = 30'h0;
      bus_a.s_rdy_ = 8'hFF;
    end
  endtask

  task automatic step(input vec_t v, input string name);
    logic [10:0] exp;
    @(negedge clk);
    drive(v.which, v.as_, v.idx, v.rdy);
    exp_q.push_back({v.cs, v.mrdy, v.err, v.busy});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(name, obs(v.which), exp);
  endtask

  initial begin
    reset_ = 1'b1;
    drive(1'b0, 1'b1, 3'd0, 8'hFF);
    #2 reset_ = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_a", obs(1'b0), {8'hFF, 1'b1, 1'b0, 1'b0});
    check("reset_b", obs(1'b1), {8'hFF, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset_ = 1'b1;

    // dut_a: N_SLAVES=8, TIMEOUT=4
    // index 1, ready immediately
    tbl.push_back(mk(0, 0, 3'd1, 8'hFD, 8'hFD, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFD, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0));
    // index 3, never ready: 4 WAIT cycles then ERR
    tbl.push_back(mk(0, 0, 3'd3, 8'hFF, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hFF, 0, 1, 1));
    tbl.push_back(mk(0, 0, 3'd4, 8'hFF, 8'hFF, 1, 0, 0));  // strobe in ERR ignored
    // index 3, other slave ready ignored, own ready in 4th WAIT cycle wins over timeout
    tbl.push_back(mk(0, 0, 3'd3, 8'hFF, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd5, 8'hFB, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd5, 8'hFB, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd5, 8'hFB, 8'hF7, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd5, 8'hF7, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3'd5, 8'hFF, 8'hFF, 1, 0, 0));  // strobe in DONE ignored
    // strobe held low, all slaves ready: 3-cycle back-to-back transactions
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFB, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFB, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 1, 0, 0));
    // highest and lowest index
    tbl.push_back(mk(0, 0, 3'd7, 8'h7F, 8'h7F, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'h7F, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 8'hFE, 8'hFE, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFE, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0));
    // dut_b: N_SLAVES=5; indices 6 and 5 out of range, 4 in range
    tbl.push_back(mk(1, 0, 3'd6, 8'hFF, 8'hFF, 0, 1, 1));
    tbl.push_back(mk(1, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(1, 0, 3'd5, 8'hFF, 8'hFF, 0, 1, 1));
    tbl.push_back(mk(1, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(1, 0, 3'd4, 8'hEF, 8'hEF, 1, 0, 1));
    tbl.push_back(mk(1, 1, 3'd0, 8'hEF, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(1, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of WAIT: selects drop at once, no completion pulse.
    step(mk(0, 0, 3'd3, 8'hFF, 8'hF7, 1, 0, 1), "rst_pre_wait");
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 8'hFF);
    #1 reset_ = 1'b0;
    #1;
    check("rst_async", obs(1'b0), {8'hFF, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("rst_hold", obs(1'b0), {8'hFF, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset_ = 1'b1;
    // First strobe after release is taken on the very next edge.
    step(mk(0, 0, 3'd1, 8'hFF, 8'hFD, 1, 0, 1), "first_req");
    step(mk(0, 1, 3'd0, 8'hFD, 8'hFF, 0, 0, 1), "first_done");
    step(mk(0, 1, 3'd0, 8'hFF, 8'hFF, 1, 0, 0), "first_idle");

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
